skew_feeder: RTL and testbench

Parametrised input skew stage that sits between the operand buffer and the edge of a LANES×LANES systolic PE array. It takes one full-width vector per accepted beat and delays lane k by k cycles, or by LANES-1-k cycles in reverse mode. Frames are delimited with a last flag; after each frame the block drains the triangle with zero bubbles. The whole pipeline stalls under output backpressure and carries a per-lane valid so PEs can gate their MACs.

---
 rtl/skew_feeder.sv | 148 ++++++++++++++
 tb/tb_skew_feeder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/skew_feeder.sv
// Input skew stage for a LANES x LANES systolic array: lane k is delayed k (or LANES-1-k) cycles.
// Optional build macro SKEW_ZERO_FILL_EN forces bubble/invalid stage data to zero.

module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic                  in_lst,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat,
  output logic                  out_lst
);
  logic [DEPTH-1:0]                 vld_pipe;
  logic [DEPTH-1:0]                 lst_pipe;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
      dat_pipe <= '0;
    end else if (adv) begin
      vld_pipe[0] <= in_vld;
      lst_pipe[0] <= in_lst;
      dat_pipe[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[DEPTH-1];
  assign out_lst = lst_pipe[DEPTH-1];
  assign out_dat = dat_pipe[DEPTH-1];
endmodule

module skew_feeder #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dir,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_lane_valid,
  output logic                        out_last
);
  localparam int CW = $clog2(LANES);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]    state;
  logic          dir_q;
  logic [CW-1:0] drain_cnt;
  logic          accept;
  logic          dir_eff;

  logic [LANES-1:0][DATA_WIDTH-1:0] in_lane, ent_dat, phys_dat, out_lane;
  logic [LANES-1:0]                 phys_vld, phys_lst, ent_lst;

  assign in_ready = out_ready && !rst && (state != DRAIN);
  assign accept   = in_valid && in_ready;
  // The first beat of a frame must already be routed with the incoming dir.
  assign dir_eff  = (state == IDLE) ? dir : dir_q;
  assign in_lane  = in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      drain_cnt <= '0;
    end else if (out_ready) begin
      case (state)
        IDLE: if (accept) begin
          dir_q <= dir;
          if (in_last) begin
            state     <= DRAIN;
            drain_cnt <= CW'(LANES-1);
          end else begin
            state <= STREAM;
          end
        end
        STREAM: if (accept && in_last) begin
          state     <= DRAIN;
          drain_cnt <= CW'(LANES-1);
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - CW'(1);
          if (drain_cnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Physical line j is always j+1 deep; reverse mode swaps which lane feeds it
  // and which output lane reads it, so the deepest line always carries last.
  for (genvar j = 0; j < LANES; j++) begin : g_line
    localparam int R = LANES - 1 - j;
    logic [DATA_WIDTH-1:0] src;

    assign src = dir_eff ? in_lane[R] : in_lane[j];
`ifdef SKEW_ZERO_FILL_EN
    assign ent_dat[j] = accept ? src : '0;
`else
    assign ent_dat[j] = src;
`endif
    if (j == LANES - 1) begin : g_top
      assign ent_lst[j] = accept && in_last;
    end else begin : g_low
      assign ent_lst[j] = 1'b0;
    end

    skew_line #(.DEPTH(j + 1), .DATA_WIDTH(DATA_WIDTH)) u_line (
      .clk     (clk),
      .rst     (rst),
      .adv     (out_ready),
      .in_vld  (accept),
      .in_dat  (ent_dat[j]),
      .in_lst  (ent_lst[j]),
      .out_vld (phys_vld[j]),
      .out_dat (phys_dat[j]),
      .out_lst (phys_lst[j])
    );

    assign out_lane[j]       = dir_q ? phys_dat[R] : phys_dat[j];
    assign out_lane_valid[j] = dir_q ? phys_vld[R] : phys_vld[j];
  end

  assign out_data  = out_lane;
  assign out_valid = |out_lane_valid;
  // Only the deepest line can ever hold a set last bit.
  assign out_last  = |phys_lst;
endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder: 4-lane vector table plus 8-lane stall and reset sequences.
`timescale 1ns/1ps
module tb_skew_feeder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-lane instance
  logic        i4_dir, i4_valid, i4_last, o4_ready, r4, o4_valid, o4_last;
  logic [63:0] i4_data, o4_data;
  logic [3:0]  o4_lv;
  // 8-lane instance
  logic         i8_dir, i8_valid, i8_last, o8_ready, r8, o8_valid, o8_last;
  logic [127:0] i8_data, o8_data;
  logic [7:0]   o8_lv;

  skew_feeder #(.LANES(4), .DATA_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .dir(i4_dir), .in_valid(i4_valid), .in_ready(r4),
    .in_data(i4_data), .in_last(i4_last), .out_ready(o4_ready), .out_valid(o4_valid),
    .out_data(o4_data), .out_lane_valid(o4_lv), .out_last(o4_last));

  skew_feeder #(.LANES(8), .DATA_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .dir(i8_dir), .in_valid(i8_valid), .in_ready(r8),
    .in_data(i8_data), .in_last(i8_last), .out_ready(o8_ready), .out_valid(o8_valid),
    .out_data(o8_data), .out_lane_valid(o8_lv), .out_last(o8_last));

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        vld, lst, dir, ordy;
    logic [63:0] dat;
    logic        exp_rdy;
    logic [3:0]  exp_lv;
    logic [63:0] exp_dat;
    logic        exp_last;
  } vec4_t;

  function automatic logic [63:0] d4(input logic [15:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [63:0] m4(input logic [3:0] lv);
    logic [63:0] m;
    for (int k = 0; k < 4; k++) m[k*16 +: 16] = {16{lv[k]}};
    return m;
  endfunction

  function automatic vec4_t mk(input logic vld, lst, dir, ordy, input logic [63:0] dat,
                               input logic rdy, input logic [3:0] lv,
                               input logic [63:0] edat, input logic elast);
    vec4_t v;
    v.vld = vld; v.lst = lst; v.dir = dir; v.ordy = ordy; v.dat = dat;
    v.exp_rdy = rdy; v.exp_lv = lv; v.exp_dat = edat; v.exp_last = elast;
    return v;
  endfunction

  function automatic logic [15:0] val8(input int b, input int k);
    return {8'(b + 1), 8'(k)};
  endfunction

  vec4_t tv[27];
  int nb, adv_cnt, bidx;
  logic ordy, exp_rdy, exp_v;

  initial begin
    // A: forward single-beat frame
    tv[0]  = mk(1,1,0,1, d4(4,3,2,1), 1, 4'b0001, d4(0,0,0,1), 0);
    tv[1]  = mk(0,0,0,1, 64'h0,       0, 4'b0010, d4(0,0,2,0), 0);
    tv[2]  = mk(0,0,0,1, 64'h0,       0, 4'b0100, d4(0,3,0,0), 0);
    tv[3]  = mk(0,0,0,1, 64'h0,       0, 4'b1000, d4(4,0,0,0), 1);
    tv[4]  = mk(0,0,0,1, 64'h0,       1, 4'b0000, 64'h0,       0);
    // B: reverse single-beat frame, dir wiggled while draining
    tv[5]  = mk(1,1,1,1, d4(4,3,2,1), 1, 4'b1000, d4(4,0,0,0), 0);
    tv[6]  = mk(0,0,0,1, 64'h0,       0, 4'b0100, d4(0,3,0,0), 0);
    tv[7]  = mk(0,0,1,1, 64'h0,       0, 4'b0010, d4(0,0,2,0), 0);
    tv[8]  = mk(0,0,0,1, 64'h0,       0, 4'b0001, d4(0,0,0,1), 1);
    tv[9]  = mk(0,0,0,1, 64'h0,       1, 4'b0000, 64'h0,       0);
    // C: 2-beat forward frame (dir=1 on beat 2 ignored), then reverse frame on IDLE re-entry
    tv[10] = mk(1,0,0,1, d4('h14,'h13,'h12,'h11), 1, 4'b0001, d4(0,0,0,'h11), 0);
    tv[11] = mk(1,1,1,1, d4('h24,'h23,'h22,'h21), 1, 4'b0011, d4(0,0,'h12,'h21), 0);
    tv[12] = mk(0,0,0,1, 64'h0, 0, 4'b0110, d4(0,'h13,'h22,0), 0);
    tv[13] = mk(0,0,0,1, 64'h0, 0, 4'b1100, d4('h14,'h23,0,0), 0);
    tv[14] = mk(0,0,0,1, 64'h0, 0, 4'b1000, d4('h24,0,0,0),    1);
    tv[15] = mk(1,1,1,1, d4('h34,'h33,'h32,'h31), 1, 4'b1000, d4('h34,0,0,0), 0);
    tv[16] = mk(0,0,0,1, 64'h0, 0, 4'b0100, d4(0,'h33,0,0),    0);
    tv[17] = mk(0,0,0,1, 64'h0, 0, 4'b0010, d4(0,0,'h32,0),    0);
    tv[18] = mk(0,0,0,1, 64'h0, 0, 4'b0001, d4(0,0,0,'h31),    1);
    tv[19] = mk(0,0,0,1, 64'h0, 1, 4'b0000, 64'h0,             0);
    // D: beat, bubble (junk on in_data), beat with dir=1 mid-frame
    tv[20] = mk(1,0,0,1, d4('h44,'h43,'h42,'h41), 1, 4'b0001, d4(0,0,0,'h41), 0);
    tv[21] = mk(0,0,0,1, 64'hdead_beef_dead_beef, 1, 4'b0010, d4(0,0,'h42,0), 0);
    tv[22] = mk(1,1,1,1, d4('h54,'h53,'h52,'h51), 1, 4'b0101, d4(0,'h43,0,'h51), 0);
    tv[23] = mk(0,0,0,1, 64'h0, 0, 4'b1010, d4('h44,0,'h52,0), 0);
    tv[24] = mk(0,0,0,1, 64'h0, 0, 4'b0100, d4(0,'h53,0,0),    0);
    tv[25] = mk(0,0,0,1, 64'h0, 0, 4'b1000, d4('h54,0,0,0),    1);
    tv[26] = mk(0,0,0,1, 64'h0, 1, 4'b0000, 64'h0,             0);

    rst = 1'b1;
    i4_dir = 0; i4_valid = 0; i4_last = 0; i4_data = '0; o4_ready = 1;
    i8_dir = 0; i8_valid = 0; i8_last = 0; i8_data = '0; o8_ready = 1;
    @(posedge clk); #1;
    chk("rst4_ready", 64'(r4), 64'd0);
    chk("rst4_lv",    64'(o4_lv), 64'd0);
    chk("rst4_data",  o4_data, 64'd0);
    chk("rst4_valid", 64'(o4_valid), 64'd0);
    chk("rst4_last",  64'(o4_last), 64'd0);
    chk("rst8_ready", 64'(r8), 64'd0);
    chk("rst8_lv",    64'(o8_lv), 64'd0);
    chk("rst8_data",  o8_data[63:0] | o8_data[127:64], 64'd0);
    rst = 1'b0;

    // 4-lane table
    for (int i = 0; i < 27; i++) begin
      i4_valid = tv[i].vld; i4_last = tv[i].lst; i4_dir = tv[i].dir;
      o4_ready = tv[i].ordy; i4_data = tv[i].dat;
      #1 chk($sformatf("v%0d_ready", i), 64'(r4), 64'(tv[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_lv", i),    64'(o4_lv), 64'(tv[i].exp_lv));
      chk($sformatf("v%0d_valid", i), 64'(o4_valid), 64'(|tv[i].exp_lv));
      chk($sformatf("v%0d_data", i),  o4_data & m4(tv[i].exp_lv), tv[i].exp_dat);
      chk($sformatf("v%0d_last", i),  64'(o4_last), 64'(tv[i].exp_last));
`ifdef SKEW_ZERO_FILL_EN
      chk($sformatf("v%0d_zfill", i), o4_data, tv[i].exp_dat);
`endif
    end
    i4_valid = 0; i4_last = 0;

    // 8-lane, 5-beat frame with a 3-cycle stall after beat 2
    nb = 0; adv_cnt = 0;
    for (int e = 1; e <= 18; e++) begin
      ordy = !(e >= 3 && e <= 5);
      o8_ready = ordy; i8_dir = 0;
      i8_valid = (nb < 5); i8_last = (nb == 4);
      for (int k = 0; k < 8; k++) i8_data[k*16 +: 16] = val8(nb, k);
      exp_rdy = ordy && (nb < 5 || adv_cnt >= 12);
      #1 chk($sformatf("s8_e%0d_ready", e), 64'(r8), 64'(exp_rdy));
      if (i8_valid && exp_rdy) nb++;
      @(posedge clk); #1;
      if (ordy) adv_cnt++;
      for (int k = 0; k < 8; k++) begin
        bidx  = adv_cnt - 1 - k;
        exp_v = (bidx >= 0 && bidx <= 4);
        chk($sformatf("s8_e%0d_lv%0d", e, k), 64'(o8_lv[k]), 64'(exp_v));
        if (exp_v)
          chk($sformatf("s8_e%0d_d%0d", e, k), 64'(o8_data[k*16 +: 16]), 64'(val8(bidx, k)));
      end
      chk($sformatf("s8_e%0d_last", e), 64'(o8_last), 64'(adv_cnt == 12));
    end
    chk("s8_beats", 64'(nb), 64'd5);
    i8_valid = 0; i8_last = 0; o8_ready = 1;

    // 8-lane reset while draining
    i8_valid = 1; i8_last = 1;
    for (int k = 0; k < 8; k++) i8_data[k*16 +: 16] = val8(7, k);
    @(posedge clk); #1;
    i8_valid = 0; i8_last = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rd_pre_lv",   64'(o8_lv), 64'h04);
    chk("rd_pre_data", 64'(o8_data[47:32]), 64'(val8(7, 2)));
    chk("rd_pre_rdy",  64'(r8), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("rd_lv",    64'(o8_lv), 64'd0);
    chk("rd_valid", 64'(o8_valid), 64'd0);
    chk("rd_data",  o8_data[63:0] | o8_data[127:64], 64'd0);
    chk("rd_last",  64'(o8_last), 64'd0);
    chk("rd_rdy",   64'(r8), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    #1 chk("rd_post_rdy", 64'(r8), 64'd1);
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      chk($sformatf("rd_post%0d_valid", e), 64'(o8_valid), 64'd0);
      chk($sformatf("rd_post%0d_last", e),  64'(o8_last), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
